// File: rtl/fir_out_requant.sv
// fir_out_requant: output requantizer placed after fir_top.
// Decimates the full-precision FIR stream, rounds (half-up) and right-shifts,
// saturates to a signed output sample, and buffers results in a show-ahead
// FIFO behind a valid/ready port. The FIR side never stalls; a push into a
// full FIFO is dropped and flagged on the sticky ovf_o.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_vld_i           strobe loading cfg_shift_i / cfg_dec_i
//   cfg_shift_i         right-shift amount
//   cfg_dec_i           decimation factor minus 1
//   data_vld_i, data_i  FIR sample stream (no ready)
//   data_vld_o, data_o  FIFO head valid / signed sample
//   data_rdy_i          consumer ready; pop on data_vld_o & data_rdy_i
//   sat_o               head sample was saturated
//   ovf_o               sticky: a sample was dropped on a full FIFO
//   fifo_cnt_o          FIFO occupancy
module fir_out_requant #(
    parameter int unsigned DATA_IN_WIDTH  = 37,
    parameter int unsigned DATA_OUT_WIDTH = 16,
    parameter int unsigned SHIFT_WIDTH    = 5,
    parameter int unsigned DEC_WIDTH      = 4,
    parameter int unsigned FIFO_AW        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_vld_i,
    input  logic [SHIFT_WIDTH-1:0]    cfg_shift_i,
    input  logic [DEC_WIDTH-1:0]      cfg_dec_i,
    input  logic                      data_vld_i,
    input  logic [DATA_IN_WIDTH-1:0]  data_i,
    output logic                      data_vld_o,
    input  logic                      data_rdy_i,
    output logic [DATA_OUT_WIDTH-1:0] data_o,
    output logic                      sat_o,
    output logic                      ovf_o,
    output logic [FIFO_AW:0]          fifo_cnt_o
);

    localparam int unsigned S1_W    = DATA_IN_WIDTH + 1;
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned ENTRY_W = DATA_OUT_WIDTH + 1;
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    // Saturation bounds expressed at stage-1 width and at output width.
    localparam logic signed [S1_W-1:0] SAT_HI =
        {{(S1_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [S1_W-1:0] SAT_LO =
        {{(S1_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};
    localparam logic [DATA_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic [DATA_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

    // Configuration and decimation state
    logic [SHIFT_WIDTH-1:0] shift_r;
    logic [DEC_WIDTH-1:0]   dec_r;
    logic [DEC_WIDTH-1:0]   dec_cnt;

    // Pipeline registers
    logic                         s1_vld;
    logic signed [S1_W-1:0]       s1_val;
    logic                         s2_vld;
    logic [DATA_OUT_WIDTH-1:0]    s2_data;
    logic                         s2_sat;

    // FIFO storage and pointers
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    // Combinational helpers
    logic                      keep;
    logic signed [S1_W-1:0]    ext;
    logic signed [S1_W-1:0]    rnd;
    logic signed [S1_W-1:0]    sum;
    logic                      sat_hi;
    logic                      sat_lo;
    logic                      full;
    logic                      pop;
    logic                      accept;
    logic                      drop;
    logic [FIFO_AW-1:0]        rd_nxt;
    logic [CNT_W-1:0]          cnt_nxt;
    logic [ENTRY_W-1:0]        push_word;
    logic [ENTRY_W-1:0]        head_nxt;

    // Keep only the first sample of each decimation group.
    assign keep = data_vld_i && (dec_cnt == '0);

    // Round-half-up: add 2^(shift-1) before the arithmetic shift.
    always_comb begin
        ext = {data_i[DATA_IN_WIDTH-1], data_i};
        rnd = '0;
        if (shift_r != '0) begin
            rnd = S1_W'(1) << (shift_r - SHIFT_WIDTH'(1));
        end
        sum = ext + rnd;
    end

    assign sat_hi = (s1_val > SAT_HI);
    assign sat_lo = (s1_val < SAT_LO);

    // FIFO control; a push into a full FIFO still succeeds if a pop frees a slot.
    assign full      = (fifo_cnt_o == CNT_W'(DEPTH));
    assign pop       = data_vld_o && data_rdy_i;
    assign accept    = s2_vld && (!full || pop);
    assign drop      = s2_vld && full && !pop;
    assign push_word = {s2_sat, s2_data};
    assign rd_nxt    = pop ? (rd_ptr + FIFO_AW'(1)) : rd_ptr;

    always_comb begin
        cnt_nxt = fifo_cnt_o;
        if (accept && !pop) begin
            cnt_nxt = fifo_cnt_o + CNT_W'(1);
        end else if (pop && !accept) begin
            cnt_nxt = fifo_cnt_o - CNT_W'(1);
        end
    end

    // Next head: the entry being written bypasses memory when it becomes head.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (accept && (wr_ptr == rd_nxt)) begin
            head_nxt = push_word;
        end
    end

    // Control, pipeline and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= '0;
            dec_r      <= '0;
            dec_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_val     <= '0;
            s2_vld     <= 1'b0;
            s2_data    <= '0;
            s2_sat     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
            data_vld_o <= 1'b0;
            data_o     <= '0;
            sat_o      <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            // A sample coinciding with cfg_vld_i uses the old config.
            if (cfg_vld_i) begin
                shift_r <= cfg_shift_i;
                dec_r   <= cfg_dec_i;
                dec_cnt <= '0;
            end else if (data_vld_i) begin
                dec_cnt <= (dec_cnt == dec_r) ? '0 : (dec_cnt + DEC_WIDTH'(1));
            end

            s1_vld <= keep;
            if (keep) begin
                s1_val <= sum >>> shift_r;
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sat  <= sat_hi || sat_lo;
                s2_data <= sat_hi ? OUT_MAX :
                           sat_lo ? OUT_MIN : s1_val[DATA_OUT_WIDTH-1:0];
            end

            if (accept) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            rd_ptr     <= rd_nxt;
            fifo_cnt_o <= cnt_nxt;
            data_vld_o <= (cnt_nxt != '0);
            // Head holds its last value while the FIFO is empty.
            if (cnt_nxt != '0) begin
                data_o <= head_nxt[DATA_OUT_WIDTH-1:0];
                sat_o  <= head_nxt[DATA_OUT_WIDTH];
            end

            // Config clear wins over a same-cycle drop.
            if (cfg_vld_i) begin
                ovf_o <= 1'b0;
            end else if (drop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // FIFO storage (no reset needed; occupancy qualifies contents)
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wr_ptr] <= push_word;
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed testbench for fir_out_requant with hand-computed expectations.
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_vld_i;
    logic [4:0]  cfg_shift_i;
    logic [3:0]  cfg_dec_i;
    logic        data_vld_i;
    logic [36:0] data_i;
    logic        data_vld_o;
    logic        data_rdy_i;
    logic [15:0] data_o;
    logic        sat_o;
    logic        ovf_o;
    logic [3:0]  fifo_cnt_o;

    int total = 0;
    int bad   = 0;

    fir_out_requant dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_vld_i  (cfg_vld_i),
        .cfg_shift_i(cfg_shift_i),
        .cfg_dec_i  (cfg_dec_i),
        .data_vld_i (data_vld_i),
        .data_i     (data_i),
        .data_vld_o (data_vld_o),
        .data_rdy_i (data_rdy_i),
        .data_o     (data_o),
        .sat_o      (sat_o),
        .ovf_o      (ovf_o),
        .fifo_cnt_o (fifo_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input int sh, input int dc);
        cfg_vld_i   = 1'b1;
        cfg_shift_i = 5'(sh);
        cfg_dec_i   = 4'(dc);
        tick();
        cfg_vld_i   = 1'b0;
    endtask

    task automatic feed(input int v);
        data_vld_i = 1'b1;
        data_i     = 37'(v);
        tick();
        data_vld_i = 1'b0;
    endtask

    // Check head then pop it (caller holds data_rdy_i high).
    task automatic read(input string tag, input int exp_d, input int exp_s);
        chk({tag, "_vld"}, int'(data_vld_o), 1);
        chk({tag, "_data"}, int'($signed(data_o)), exp_d);
        chk({tag, "_sat"}, int'(sat_o), exp_s);
        tick();
    endtask

    initial begin
        rst = 1'b1; cfg_vld_i = 1'b0; cfg_shift_i = '0; cfg_dec_i = '0;
        data_vld_i = 1'b0; data_i = '0; data_rdy_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_vld", int'(data_vld_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_sat", int'(sat_o), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        chk("rst_cnt", int'(fifo_cnt_o), 0);

        // 1. Pass-through, 3-cycle latency
        data_rdy_i = 1'b1;
        data_vld_i = 1'b1; data_i = 37'(100);
        tick();
        chk("t1_vld_e1", int'(data_vld_o), 0);
        data_i = 37'(-7);
        tick();
        data_vld_i = 1'b0;
        chk("t1_vld_e2", int'(data_vld_o), 0);
        tick();
        chk("t1_vld_e3", int'(data_vld_o), 1);
        chk("t1_d0", int'($signed(data_o)), 100);
        chk("t1_s0", int'(sat_o), 0);
        chk("t1_cnt_e3", int'(fifo_cnt_o), 1);
        tick();
        chk("t1_vld_e4", int'(data_vld_o), 1);
        chk("t1_d1", int'($signed(data_o)), -7);
        tick();
        chk("t1_vld_e5", int'(data_vld_o), 0);
        chk("t1_cnt_e5", int'(fifo_cnt_o), 0);
        chk("t1_hold", int'($signed(data_o)), -7);

        // 2. Rounding, shift=4
        data_rdy_i = 1'b0;
        cfg(4, 0);
        feed(24); feed(23); feed(-24); feed(-25);
        tick(); tick(); tick();
        chk("t2_cnt", int'(fifo_cnt_o), 4);
        data_rdy_i = 1'b1;
        read("t2_a", 2, 0);
        read("t2_b", 1, 0);
        read("t2_c", -1, 0);
        read("t2_d", -2, 0);
        chk("t2_empty", int'(data_vld_o), 0);

        // 3. Saturation, shift=0
        data_rdy_i = 1'b0;
        cfg(0, 0);
        feed(40000); feed(-40000); feed(32767);
        tick(); tick(); tick();
        data_rdy_i = 1'b1;
        read("t3_a", 32767, 1);
        read("t3_b", -32768, 1);
        read("t3_c", 32767, 0);
        chk("t3_empty", int'(data_vld_o), 0);

        // 4. Decimation by 4, then by 2 after a mid-stream reconfig
        data_rdy_i = 1'b0;
        cfg(0, 3);
        for (int i = 1; i <= 8; i++) feed(i);
        tick(); tick(); tick();
        chk("t4_cnt", int'(fifo_cnt_o), 2);
        data_rdy_i = 1'b1;
        read("t4_a", 1, 0);
        read("t4_b", 5, 0);
        chk("t4_empty", int'(data_vld_o), 0);
        data_rdy_i = 1'b0;
        cfg(0, 1);
        for (int i = 9; i <= 14; i++) feed(i);
        tick(); tick(); tick();
        chk("t4_cnt2", int'(fifo_cnt_o), 3);
        data_rdy_i = 1'b1;
        read("t4_c", 9, 0);
        read("t4_d", 11, 0);
        read("t4_e", 13, 0);
        chk("t4_empty2", int'(data_vld_o), 0);

        // 5. Backpressure and overflow
        data_rdy_i = 1'b0;
        cfg(0, 0);
        for (int i = 1; i <= 10; i++) feed(i);
        chk("t5_cnt_w8", int'(fifo_cnt_o), 8);
        chk("t5_ovf_w8", int'(ovf_o), 0);
        tick();
        chk("t5_cnt_w9", int'(fifo_cnt_o), 8);
        chk("t5_ovf_w9", int'(ovf_o), 1);
        tick();
        chk("t5_head", int'($signed(data_o)), 1);
        cfg(0, 0);
        chk("t5_ovf_clr", int'(ovf_o), 0);
        chk("t5_cnt_keep", int'(fifo_cnt_o), 8);
        feed(11);
        tick();
        data_rdy_i = 1'b1;
        tick();
        chk("t5_cnt_pp", int'(fifo_cnt_o), 8);
        chk("t5_ovf_pp", int'(ovf_o), 0);
        for (int i = 2; i <= 8; i++) read($sformatf("t5_r%0d", i), i, 0);
        read("t5_r11", 11, 0);
        chk("t5_empty", int'(data_vld_o), 0);
        chk("t5_cnt0", int'(fifo_cnt_o), 0);

        // 6. Reset with entries queued and samples in flight
        data_rdy_i = 1'b0;
        for (int i = 21; i <= 25; i++) feed(i);
        chk("t6_cnt_pre", int'(fifo_cnt_o), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_vld", int'(data_vld_o), 0);
        chk("t6_cnt", int'(fifo_cnt_o), 0);
        chk("t6_ovf", int'(ovf_o), 0);
        chk("t6_data", int'(data_o), 0);
        data_rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t6_ghost%0d", i), int'(data_vld_o), 0);
        end
        chk("t6_cnt_end", int'(fifo_cnt_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
